// File: rtl/input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_pkg
//  Description : Shared types and constants for the arcade input conditioner.
//                Holds the coin pulse shaper state encoding and the bit
//                positions of the four joystick directions in joystick_0.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_pkg;

    // Coin pulse shaper states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        GAP      = 2'd2,
        WAIT_REL = 2'd3
    } coin_state_t;

    // Direction bit positions in joystick_0
    localparam int DIR_DOWN  = 0;
    localparam int DIR_UP    = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

endpackage : input_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : Two-flop synchroniser followed by a tick-driven debouncer
//                for one raw input bit. The clean output only follows the
//                synchronised input after DEB_TICKS consecutive ticks on
//                which the two disagree.
//  Ports       : clk_sys  - system clock
//                reset_n  - asynchronous active-low reset
//                raw      - asynchronous raw input bit
//                tick     - one-cycle debounce timebase strobe
//                deb      - debounced, clk_sys-domain output bit
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit #(
    parameter int DEB_TICKS = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw,
    input  logic tick,
    output logic deb
);

    localparam logic [3:0] C_CNT_LAST = 4'(DEB_TICKS - 1);

    logic       r_meta;
    logic       r_sync;
    logic       r_deb;
    logic [3:0] r_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_deb  <= 1'b0;
            r_cnt  <= 4'd0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
            if (tick) begin
                if (r_sync == r_deb) begin
                    // Any agreeing tick restarts the stability count
                    r_cnt <= 4'd0;
                end else if (r_cnt == C_CNT_LAST) begin
                    r_deb <= r_sync;
                    r_cnt <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    assign deb = r_deb;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/arcade_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_input_conditioner
//  Description : Conditions the raw hps_io joystick_0 vector before the
//                per-game input mapping: synchronises and debounces every
//                bit, shapes the coin bit into a fixed-length rate-limited
//                pulse, and optionally rotates the four directions into
//                diagonal pairs. All outputs are registered in clk_sys.
//  Ports       : clk_sys    - system clock
//                reset_n    - asynchronous active-low reset
//                joy_raw    - raw joystick_0 vector (asynchronous)
//                diag_en    - diagonal joystick mode, quasi-static
//                joy_clean  - conditioned joystick vector
//                coin_pulse - shaped coin pulse
//                tick       - one-cycle timebase strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_conditioner #(
    parameter int TICK_DIV       = 50000,
    parameter int DEB_TICKS      = 4,
    parameter int COIN_BIT       = 7,
    parameter int COIN_TICKS     = 50,
    parameter int COIN_GAP_TICKS = 100
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] joy_raw,
    input  logic        diag_en,
    output logic [15:0] joy_clean,
    output logic        coin_pulse,
    output logic        tick
);

    import input_pkg::*;

    localparam int              C_PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [C_PW-1:0] C_PRESC_LAST = C_PW'(TICK_DIV - 1);
    localparam logic [7:0]      C_PULSE_LAST = 8'(COIN_TICKS - 1);
    localparam logic [7:0]      C_GAP_LAST   = 8'(COIN_GAP_TICKS - 1);

    // ------------------------------------------------------------------
    // Prescaler: tick strobes as the count wraps back to zero
    // ------------------------------------------------------------------
    logic [C_PW-1:0] r_presc;
    logic            r_tick;
    logic            r_tick_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_presc  <= '0;
            r_tick   <= 1'b0;
            r_tick_d <= 1'b0;
        end else begin
            r_tick_d <= r_tick;
            if (r_presc == C_PRESC_LAST) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_presc <= r_presc + C_PW'(1);
                r_tick  <= 1'b0;
            end
        end
    end

    assign tick = r_tick;

    // ------------------------------------------------------------------
    // Per-bit synchroniser and debouncer
    // ------------------------------------------------------------------
    logic [15:0] w_deb;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bit
            debounce_bit #(
                .DEB_TICKS (DEB_TICKS)
            ) u_debounce_bit (
                .clk_sys (clk_sys),
                .reset_n (reset_n),
                .raw     (joy_raw[gi]),
                .tick    (r_tick),
                .deb     (w_deb[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Coin pulse shaper
    // The debounced coin bit changes on the edge that consumes a tick, so
    // the shaper reacts one cycle later. It counts on the tick delayed by
    // one cycle to stay phase-aligned, which makes the pulse exactly
    // COIN_TICKS*TICK_DIV cycles and the gap COIN_GAP_TICKS*TICK_DIV.
    // ------------------------------------------------------------------
    coin_state_t r_state;
    coin_state_t w_state_nxt;
    logic [7:0]  r_coin_cnt;
    logic [7:0]  w_coin_cnt_nxt;
    logic        w_pulse_nxt;
    logic        r_coin_pulse;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_coin_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_coin_cnt <= w_coin_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_coin_cnt_nxt = r_coin_cnt;
        case (r_state)
            IDLE: begin
                if (w_deb[COIN_BIT]) begin
                    w_state_nxt    = PULSE;
                    w_coin_cnt_nxt = 8'd0;
                end
            end
            PULSE: begin
                if (r_tick_d) begin
                    if (r_coin_cnt == C_PULSE_LAST) begin
                        w_state_nxt    = GAP;
                        w_coin_cnt_nxt = 8'd0;
                    end else begin
                        w_coin_cnt_nxt = r_coin_cnt + 8'd1;
                    end
                end
            end
            GAP: begin
                if (r_tick_d) begin
                    if (r_coin_cnt == C_GAP_LAST) begin
                        w_state_nxt    = WAIT_REL;
                        w_coin_cnt_nxt = 8'd0;
                    end else begin
                        w_coin_cnt_nxt = r_coin_cnt + 8'd1;
                    end
                end
            end
            WAIT_REL: begin
                // A held coin parks here so it can only ever pulse once
                if (!w_deb[COIN_BIT]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_coin_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Registered from the next state so coin_pulse tracks PULSE exactly
    assign w_pulse_nxt = (w_state_nxt == PULSE);

    // ------------------------------------------------------------------
    // Diagonal rotation and output assembly
    // ------------------------------------------------------------------
    logic [3:0]  w_rot;
    logic [15:0] w_joy_nxt;
    logic [15:0] r_joy_clean;

    always_comb begin
        w_rot = w_deb[3:0];
        if (diag_en) begin
            w_rot[DIR_DOWN]  = w_deb[DIR_DOWN]  & w_deb[DIR_LEFT];
            w_rot[DIR_UP]    = w_deb[DIR_UP]    & w_deb[DIR_RIGHT];
            w_rot[DIR_LEFT]  = w_deb[DIR_RIGHT] & w_deb[DIR_DOWN];
            w_rot[DIR_RIGHT] = w_deb[DIR_LEFT]  & w_deb[DIR_UP];
        end
    end

    always_comb begin
        w_joy_nxt           = w_deb;
        w_joy_nxt[3:0]      = w_rot;
        w_joy_nxt[COIN_BIT] = w_pulse_nxt;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_joy_clean  <= 16'd0;
            r_coin_pulse <= 1'b0;
        end else begin
            r_joy_clean  <= w_joy_nxt;
            r_coin_pulse <= w_pulse_nxt;
        end
    end

    assign joy_clean  = r_joy_clean;
    assign coin_pulse = r_coin_pulse;

endmodule : arcade_input_conditioner
`default_nettype wire

// File: tb/tb_arcade_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arcade_input_conditioner
//  Description : Directed self-checking bench for arcade_input_conditioner
//                with TICK_DIV=4, DEB_TICKS=4, COIN_TICKS=5,
//                COIN_GAP_TICKS=3 (20-cycle coin pulse, 12-cycle gap).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arcade_input_conditioner;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] joy_raw = 16'h0000;
    logic        diag_en = 1'b0;
    logic [15:0] joy_clean;
    logic        coin_pulse;
    logic        tick;

    int n_total   = 0;
    int n_pass    = 0;
    int mirror_err = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_conditioner #(
        .TICK_DIV       (4),
        .DEB_TICKS      (4),
        .COIN_BIT       (7),
        .COIN_TICKS     (5),
        .COIN_GAP_TICKS (3)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .joy_raw    (joy_raw),
        .diag_en    (diag_en),
        .joy_clean  (joy_clean),
        .coin_pulse (coin_pulse),
        .tick       (tick)
    );

`define CHECK(TAG, OBS, EXP) \
    begin \
        n_total++; \
        assert ((OBS) === (EXP)) n_pass++; \
        else $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); \
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Waits up to max_wait cycles for coin_pulse to rise, then measures its
    // width. start is the cycle index of the first high sample (-1 if none).
    task automatic measure_pulse(input int max_wait, output int start, output int width);
        start = -1;
        width = 0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk_sys);
            if (joy_clean[7] !== coin_pulse) mirror_err++;
            if (coin_pulse) begin
                start = i + 1;
                break;
            end
        end
        if (start >= 0) begin
            width = 1;
            for (int j = 0; j < 100; j++) begin
                @(negedge clk_sys);
                if (joy_clean[7] !== coin_pulse) mirror_err++;
                if (coin_pulse) width++;
                else break;
            end
        end
    endtask

    initial begin
        int first_tick;
        int first_j0;
        int tick_cnt;
        int seen5;
        int first5;
        int pulses;
        int hi;
        int glitch_at;
        logic prev;
        int start;
        int width;

        // ---------------- reset with all inputs high ----------------
        reset_n = 1'b0;
        joy_raw = 16'hFFFF;
        wait_cycles(3);
        `CHECK("reset_joy_clean", joy_clean, 16'h0000)
        `CHECK("reset_coin_pulse", coin_pulse, 1'b0)
        `CHECK("reset_tick", tick, 1'b0)

        reset_n    = 1'b1;
        first_tick = -1;
        first_j0   = -1;
        tick_cnt   = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_sys);
            if (tick) begin
                tick_cnt++;
                if (first_tick < 0) first_tick = k;
            end
            if (joy_clean[0] && first_j0 < 0) first_j0 = k;
        end
        `CHECK("first_tick_cycle", first_tick, 4)
        `CHECK("tick_count_30cyc", tick_cnt, 7)
        `CHECK("bit0_latency_window", (first_j0 > 16 && first_j0 <= 23), 1'b1)

        // Async reset clears outputs without waiting for a clock edge
        reset_n = 1'b0;
        joy_raw = 16'h0000;
        #1;
        `CHECK("async_reset_clear", joy_clean, 16'h0000)
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(40);
        `CHECK("idle_zero_input", joy_clean, 16'h0000)

        // ---------------- glitch rejection on bit 5 ----------------
        seen5 = 0;
        joy_raw[5] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (joy_clean[5]) seen5 = 1;
        end
        joy_raw[5] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_sys);
            if (joy_clean[5]) seen5 = 1;
        end
        `CHECK("glitch_10cyc_rejected", seen5, 0)

        first5 = -1;
        joy_raw[5] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            if (joy_clean[5] && first5 < 0) first5 = i + 1;
        end
        `CHECK("hold_40cyc_asserts", joy_clean[5], 1'b1)
        `CHECK("hold_latency_window", (first5 >= 16 && first5 <= 24), 1'b1)
        joy_raw[5] = 1'b0;
        wait_cycles(40);
        `CHECK("bit5_released", joy_clean[5], 1'b0)

        // ---------------- diagonal rotation ----------------
        diag_en = 1'b1;
        joy_raw = 16'h0005;                 // down + left
        wait_cycles(30);
        `CHECK("diag_down_left", joy_clean[3:0], 4'b0001)
        joy_raw = 16'h000A;                 // up + right
        wait_cycles(30);
        `CHECK("diag_up_right", joy_clean[3:0], 4'b0010)
        joy_raw = 16'h0001;                 // down only
        wait_cycles(30);
        `CHECK("diag_down_only", joy_clean[3:0], 4'b0000)
        diag_en = 1'b0;
        wait_cycles(2);
        `CHECK("straight_down_only", joy_clean, 16'h0001)
        joy_raw = 16'h0000;
        wait_cycles(30);

        // ------- coin hold with a short release just after the pulse -------
        pulses    = 0;
        hi        = 0;
        glitch_at = -1;
        prev      = 1'b0;
        joy_raw[7] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            if (joy_clean[7] !== coin_pulse) mirror_err++;
            if (coin_pulse && !prev) pulses++;
            if (coin_pulse) hi++;
            if (prev && !coin_pulse && glitch_at < 0) glitch_at = i;
            prev = coin_pulse;
            // 8-cycle release inside the gap, too short to debounce
            joy_raw[7] = !(glitch_at >= 0 && i < glitch_at + 8);
        end
        `CHECK("coin_hold_pulse_count", pulses, 1)
        `CHECK("coin_hold_pulse_width", hi, 20)
        `CHECK("coin_pulse_ended", (glitch_at >= 0), 1'b1)

        // ---------------- release, then a fresh press ----------------
        joy_raw[7] = 1'b0;
        wait_cycles(60);
        `CHECK("coin_idle_after_release", coin_pulse, 1'b0)
        joy_raw[7] = 1'b1;
        measure_pulse(40, start, width);
        `CHECK("second_pulse_latency", (start >= 16 && start <= 24), 1'b1)
        `CHECK("second_pulse_width", width, 20)

        // ---------------- async reset mid-pulse ----------------
        joy_raw[7] = 1'b0;
        wait_cycles(60);
        joy_raw[7] = 1'b1;
        measure_pulse(40, start, width);
        `CHECK("third_pulse_seen", (start > 0), 1'b1)
        // measure_pulse already consumed the pulse; start another with reset
        reset_n = 1'b0;
        wait_cycles(2);
        reset_n = 1'b1;
        measure_pulse(40, start, width);
        `CHECK("pre_reset_pulse_seen", (start > 0 && width == 20), 1'b1)
        joy_raw[7] = 1'b0;
        wait_cycles(60);
        joy_raw[7] = 1'b1;
        start = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            if (coin_pulse) begin
                start = i + 1;
                break;
            end
        end
        `CHECK("mid_pulse_start_seen", (start > 0), 1'b1)
        wait_cycles(7);
        `CHECK("mid_pulse_still_high", coin_pulse, 1'b1)
        reset_n = 1'b0;
        #1;
        `CHECK("mid_pulse_reset_coin", coin_pulse, 1'b0)
        `CHECK("mid_pulse_reset_joy", joy_clean, 16'h0000)
        wait_cycles(3);
        reset_n = 1'b1;
        // Coin still held: must re-debounce from cleared state, then pulse
        measure_pulse(40, start, width);
        `CHECK("post_reset_latency", (start >= 16 && start <= 24), 1'b1)
        `CHECK("post_reset_width", width, 20)
        `CHECK("coin_mirror_on_joy7", mirror_err, 0)

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_arcade_input_conditioner
`default_nettype wire
